// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue port bundle between the I-cache response side and the decode stage.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface inst_fetch_queue_if #(
  parameter int unsigned AW = 2
);
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_adel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  logic [5:0]  out_op;
  logic [5:0]  out_funct;
  logic [5:0]  out_rs;
  logic [5:0]  out_rt;
  logic        out_va1;
  logic        flush;
  logic [AW:0] count;

  modport slave (
    input  in_valid, in_pc, in_inst, in_adel, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, out_adel,
    output out_op, out_funct, out_rs, out_rt, out_va1, count
  );

  modport master (
    output in_valid, in_pc, in_inst, in_adel, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, out_adel,
    input  out_op, out_funct, out_rs, out_rt, out_va1, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Registered instruction queue between the I-cache and decode. It presents the head entry
// with pre-sliced decode fields and supports a redirect flush.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input logic                clk,
  input logic                resetn,
  inst_fetch_queue_if.slave  bus
);

  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        adel_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  // Readiness comes from occupancy only, so a full queue refuses a push even while popping.
  assign full      = (count_q == CntFull);
  assign not_empty = (count_q != '0);
  assign push      = bus.in_valid && !full && !bus.flush;
  assign pop       = not_empty && bus.out_ready && !bus.flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // A faulting fetch keeps its PC for EPC but never hands a real opcode to decode.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= bus.in_pc;
      inst_mem[wr_ptr_q] <= bus.in_adel ? 32'h0 : bus.in_inst;
      adel_mem[wr_ptr_q] <= bus.in_adel;
    end
  end

  logic [31:0] head_inst;

  always_comb begin
    head_inst    = not_empty ? inst_mem[rd_ptr_q] : 32'h0;
    bus.out_pc   = not_empty ? pc_mem[rd_ptr_q]   : 32'h0;
    bus.out_adel = not_empty ? adel_mem[rd_ptr_q] : 1'b0;
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = not_empty;
  assign bus.out_va1   = not_empty;
  assign bus.out_inst  = head_inst;
  assign bus.out_op    = head_inst[31:26];
  assign bus.out_funct = head_inst[5:0];
  assign bus.out_rs    = {1'b0, head_inst[25:21]};
  assign bus.out_rt    = {1'b0, head_inst[20:16]};
  assign bus.count     = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, FIFO order, full/wrap, flush, address error
// and asynchronous reset.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  inst_fetch_queue_if #(.AW(2)) bus ();

  inst_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    bus.in_adel  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h1234_5678;
    bus.in_inst   = 32'hFFFF_FFFF;
    bus.in_adel   = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held with in_valid high
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_op",        32'(bus.out_op),    32'd0);
    chk("rst_va1",       32'(bus.out_va1),   32'd0);

    // Release mid-cycle, first push lands on the next edge
    resetn      = 1'b1;
    bus.in_pc   = 32'hBFC0_0000;
    bus.in_inst = 32'h2408_0005;
    tick();
    bus.in_valid = 1'b0;
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_op",    32'(bus.out_op),    32'h09);
    chk("first_rs",    32'(bus.out_rs),    32'd0);
    chk("first_rt",    32'(bus.out_rt),    32'd8);
    chk("first_funct", 32'(bus.out_funct), 32'h05);
    chk("first_pc",    bus.out_pc,         32'hBFC0_0000);
    chk("first_count", 32'(bus.count),     32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("empty_count", 32'(bus.count),    32'd0);
    chk("empty_pc",    bus.out_pc,        32'd0);
    chk("empty_inst",  bus.out_inst,      32'd0);
    chk("empty_va1",   32'(bus.out_va1),  32'd0);

    // Fill to capacity; a fifth push is refused
    for (int i = 1; i <= 4; i++) push_one(32'h100 + 32'(i), 32'(i));
    chk("full_count", 32'(bus.count),    32'd4);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h5;
    tick();
    chk("full_hold_count", 32'(bus.count), 32'd4);
    // Popping while full still refuses the push
    bus.out_ready = 1'b1;
    chk("full_pop_ready", 32'(bus.in_ready), 32'd0);
    chk("drain_1", bus.out_inst, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), bus.out_inst, 32'(i));
      tick();
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_count", 32'(bus.count),     32'd0);
    bus.out_ready = 1'b0;

    // Concurrent push/pop at count 2 across several pointer wraps
    push_one(32'h0, 32'd100);
    push_one(32'h4, 32'd101);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_inst = 32'd102 + 32'(k);
      chk($sformatf("conc_head_%0d", k), bus.out_inst, 32'd100 + 32'(k));
      tick();
      chk($sformatf("conc_count_%0d", k), 32'(bus.count), 32'd2);
    end
    bus.in_valid = 1'b0;
    chk("conc_tail_a", bus.out_inst, 32'd120);
    tick();
    chk("conc_tail_b", bus.out_inst, 32'd121);
    tick();
    chk("conc_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Flush with a same-cycle push and pop
    for (int i = 0; i < 3; i++) push_one(32'h0, 32'h200 + 32'(i));
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_count", 32'(bus.count),     32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("flush_stays_empty", 32'(bus.out_valid), 32'd0);
    push_one(32'h44, 32'h300);
    chk("post_flush_head", bus.out_inst, 32'h300);
    chk("post_flush_cnt",  32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Address error: instruction zeroed, PC kept
    bus.in_valid = 1'b1;
    bus.in_adel  = 1'b1;
    bus.in_inst  = 32'h8C01_0000;
    bus.in_pc    = 32'h0000_0003;
    tick();
    bus.in_valid = 1'b0;
    bus.in_adel  = 1'b0;
    chk("adel_flag", 32'(bus.out_adel), 32'd1);
    chk("adel_inst", bus.out_inst,      32'd0);
    chk("adel_op",   32'(bus.out_op),   32'd0);
    chk("adel_rt",   32'(bus.out_rt),   32'd0);
    chk("adel_pc",   bus.out_pc,        32'h0000_0003);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("adel_popped", 32'(bus.out_adel), 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) push_one(32'h0, 32'h400 + 32'(i));
    chk("pre_arst_count", 32'(bus.count), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count),     32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    #1;
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Registered instruction queue between the instruction-cache response port and the decode stage.
- Buffers fetched {pc, instruction, address-error} entries and decouples I-cache latency from decode stalls.
- Presents the head instruction with pre-sliced op/funct/rs/rt fields and a valid bit, in the exact widths the instruction-code converter consumes.
- Supports a pipeline flush from branch/exception redirect.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, 2..16.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  I-cache response valid.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_inst  input  32  fetched instruction word.
- in_adel  input  1  fetch address error (misaligned PC).
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction word.
- out_adel  output  1  head address-error flag.
- out_op  output  6  out_inst[31:26].
- out_funct  output  6  out_inst[5:0].
- out_rs  output  6  {1'b0, out_inst[25:21]}.
- out_rt  output  6  {1'b0, out_inst[20:16]}.
- out_va1  output  1  equals out_valid; decoder valid qualifier.
- flush  input  1  discard all queued entries.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1. Storage contents need not be reset.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It is registered-derived only and never depends on out_ready, so a full queue refuses a push even while popping.
- out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible at the head after edge N; minimum push-to-out_valid is 1 cycle. There is no combinational bypass from in_* to out_*.
- Head outputs come from storage[rd_ptr]. When count==0, out_pc=0, out_inst=0, out_adel=0, and the sliced fields are 0. The decoder therefore sees op=0/funct=0 with va1=0.
- When in_adel=1 on push, the stored inst is forced to 32'h0 and out_adel=1 at the head. The PC is kept for EPC.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are AW bits and wrap modulo DEPTH naturally. count is tracked separately, so the full/empty distinction uses count, not pointer equality.
- flush has highest priority. At the next edge: rd_ptr=wr_ptr=0, count=0. A same-cycle push is dropped and a same-cycle pop is suppressed. in_ready stays 1 during the flush cycle.
- Reset asserted mid-operation clears the queue immediately (asynchronously). The first push is accepted on the first edge after resetn rises.
- Field slicing is purely combinational from out_inst. rs/rt are zero-extended from 5 to 6 bits.

Test Plan:
- Reset: hold resetn=0 with in_valid=1 → out_valid=0, in_ready=1, count=0, out_op=0, out_va1=0. Release, push pc=0xBFC00000, inst=0x24080005 → one cycle later out_valid=1, out_op=6'b001001, out_rs=0, out_rt=6'd8, out_pc=0xBFC00000.
- Full/drain: out_ready=0, push 4 entries (inst 0x1,0x2,0x3,0x4) → count=4, in_ready=0, and a 5th in_valid is ignored. Raise out_ready → out_inst reads 0x1,0x2,0x3,0x4 on consecutive cycles, then out_valid=0.
- Concurrent push/pop at count=2, held for 20 cycles with incrementing inst → count stays 2. Output order is strictly FIFO across ≥4 pointer wraps, with no loss or duplication.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 → next cycle count=0 and out_valid=0. The flushed-cycle input never appears at the output.
- Address error: push in_adel=1, in_inst=0x8C010000, in_pc=0x00000003 → head shows out_adel=1, out_inst=0, out_op=0, out_pc=0x00000003.
- Async reset mid-stream: count=3, drop resetn between clock edges → count=0 and out_valid=0 without waiting for a clock edge.
